// File: rtl/mem_access.sv
// Memory-access stage: drives a request/ready data-memory bus and extends loads for write-back.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module mem_access #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_result,
   input  logic [31:0] rs2_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem_type,
   output logic [31:0] load_data,
   output logic        stall,
   output logic        bus_error,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic        misaligned,
`endif
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q;
   logic [1:0]  off_q;
   logic [2:0]  type_q;

   logic        access;
   logic        fault;
   logic        start;
   logic        ready_hit;
   logic        tmo_hit;
   logic [3:0]  strb_n;
   logic [31:0] wdata_n;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ext;

   assign access = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      fault = 1'b0;
      case (mem_type[1:0])
         2'b00:   fault = 1'b0;
         2'b01:   fault = alu_result[0];
         default: fault = |alu_result[1:0];
      endcase
   end
`else
   assign fault = 1'b0;
`endif

   assign start     = (state_q == StIdle) & access & ~fault;
   assign ready_hit = (state_q == StBusy) & dmem_ready;
   // Ready on the final wait cycle wins over the timeout.
   assign tmo_hit   = (state_q == StBusy) & ~dmem_ready & (cnt_q == CntLast);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StBusy;
         StBusy:  if (ready_hit || tmo_hit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Combinational outputs
   always_comb begin
      stall = 1'b0;
      case (state_q)
         StIdle:  stall = start;
         StBusy:  stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = (state_q == StIdle) & access & fault;
`endif

   // Store lane steering
   always_comb begin
      strb_n  = 4'b1111;
      wdata_n = rs2_data;
      case (mem_type[1:0])
         2'b00: begin
            strb_n  = 4'b0001 << alu_result[1:0];
            wdata_n = {4{rs2_data[7:0]}};
         end
         2'b01: begin
            strb_n  = alu_result[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{rs2_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane selection and extension, using the offset/type captured at request time
   always_comb begin
      case (off_q)
         2'd0:    byte_sel = dmem_rdata[7:0];
         2'd1:    byte_sel = dmem_rdata[15:8];
         2'd2:    byte_sel = dmem_rdata[23:16];
         default: byte_sel = dmem_rdata[31:24];
      endcase
      half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (type_q[1:0])
         2'b00:   ext = {{24{~type_q[2] & byte_sel[7]}}, byte_sel};
         2'b01:   ext = {{16{~type_q[2] & half_sel[15]}}, half_sel};
         default: ext = dmem_rdata;
      endcase
   end

   // Bus and write-back registers
   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'h0;
         dmem_wdata <= 32'h0;
         dmem_wstrb <= 4'h0;
         load_data  <= 32'h0;
         bus_error  <= 1'b0;
         cnt_q      <= 8'h0;
         off_q      <= 2'b00;
         type_q     <= 3'b000;
      end else begin
         bus_error <= 1'b0;
         if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_wdata <= wdata_n;
            dmem_wstrb <= strb_n;
            off_q      <= alu_result[1:0];
            type_q     <= mem_type;
            cnt_q      <= 8'h0;
         end else if (ready_hit) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (!dmem_we) load_data <= ext;
         end else if (tmo_hit) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            load_data <= 32'h0;
            bus_error <= 1'b1;
         end else if (state_q == StBusy) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage placed directly downstream of the execute stage. It takes the ALU result as the effective address and rs2 data as store data, then runs a request/ready transaction on the data-memory bus. Loads are returned to write-back sign- or zero-extended. While a transaction is outstanding, the block holds `stall` so the rest of the core freezes its PC and register-file write.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum `dmem_ready` wait cycles before the access is aborted; range 1–255.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `alu_result` input 32: effective address from execute.
- `rs2_data` input 32: store data.
- `mem_read` input 1: current instruction is a load.
- `mem_write` input 1: current instruction is a store; never high together with `mem_read`.
- `mem_type` input 3: funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `load_data` output 32: extended load result for write-back.
- `stall` output 1: freeze request to PC/regfile.
- `bus_error` output 1: one-cycle pulse on timeout.
- `misaligned` output 1: one-cycle pulse on misaligned access; present only with the macro (see Configuration).
- `dmem_req` output 1: bus request.
- `dmem_we` output 1: write enable.
- `dmem_addr` output 32: word address, bits [1:0] = 0.
- `dmem_wdata` output 32: lane-replicated store data.
- `dmem_wstrb` output 4: byte strobes.
- `dmem_ready` input 1: memory accepted/completed the access.
- `dmem_rdata` input 32: read word, valid when `dmem_ready` = 1.

## Operation

The FSM has three states: IDLE, BUSY and DONE.

- **IDLE**
  - With `access = mem_read | mem_write` and no fault:
    - `stall` = 1 combinationally.
    - Register `dmem_req` = 1, `dmem_we` = `mem_write`, the address, wdata and strobe.
    - Clear the wait counter; go to BUSY.
  - Without access: stay in IDLE, `stall` = 0.
- **BUSY**
  - `stall` = 1.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_wstrb` stay stable until `dmem_ready` is sampled high.
  - On ready:
    - Drop `dmem_req`.
    - For a load, register the extended `dmem_rdata` into `load_data`.
    - Go to DONE.
  - If the counter reaches `TIMEOUT` without ready:
    - Drop `dmem_req`.
    - Set `load_data` = 0 and pulse `bus_error` in the DONE cycle.
    - Go to DONE.
- **DONE**
  - `stall` = 0; `load_data` is valid for write-back.
  - Always return to IDLE. The core advances at this edge, so a back-to-back memory instruction is seen in the following IDLE cycle.

Lane rules, with `o` = `addr[1:0]`:
- **Byte**
  - `wstrb` = 0001 << `o`.
  - `wdata` = {4{`rs2[7:0]`}}.
  - Load = byte lane `o`, sign-extended (B) or zero-extended (BU).
- **Half**
  - `wstrb` = 0011 << (`o[1]`·2).
  - `wdata` = {2{`rs2[15:0]`}}.
  - Load = half `o[1]`, extended per H/HU.
- **Word**
  - `wstrb` = 1111.
  - `wdata` = `rs2`.
  - Load = full word.
- Stores leave `load_data` unchanged.

## Timing

- **Reset values:** state = IDLE; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, `load_data`, `bus_error`, `misaligned` = 0; counter = 0. With no access input, `stall` = 0 after reset.
- **Latency:** minimum 3 cycles per memory instruction (IDLE request, BUSY with immediate ready, DONE). Each wait cycle of `dmem_ready` adds one. Non-memory instructions add 0 cycles.
- **Bus sampling:** `dmem_ready` is ignored outside BUSY.
- **Reset during BUSY:** `dmem_req` drops at the reset edge and the transaction is abandoned; the memory model must tolerate this.
- **Timeout boundary:** ready arriving on the same edge the counter hits `TIMEOUT` counts as success; no error.
- **Counter:** 8-bit; it cannot wrap because `TIMEOUT` ≤ 255.

## Configuration

The only configuration macro is `MEM_MISALIGN_TRAP_EN`.

- **Defined:** a half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, counts as a fault.
  - In IDLE no request is issued and the state stays IDLE.
  - `misaligned` pulses 1 for that cycle and `stall` = 0.
  - `load_data` is unchanged and no write occurs.
- **Undefined:** low address bits outside the access width are ignored (half uses `addr[1]` only; word is forced aligned).
  - `misaligned` is tied to 0.

## Test plan

- **LW with immediate ready:** `alu_result` = 0x104, `dmem_rdata` = 0xDEADBEEF with ready at the first BUSY cycle → `dmem_addr` = 0x104, `stall` high 2 cycles, `load_data` = 0xDEADBEEF in DONE.
- **SB:** addr 0x203, rs2 = 0x12345678 → `dmem_wstrb` = 1000, `dmem_wdata` = 0x78787878, `dmem_we` = 1.
- **LB / LHU:** LB at addr 0x1 with rdata 0x0000_80FF → `load_data` = 0xFFFFFF80. LHU at addr 0x2 with rdata 0xBEEF_0000 → `load_data` = 0x0000BEEF.
- **Ready held low:** with `TIMEOUT` = 4 → request held stable for 4 cycles, then `bus_error` pulse, `load_data` = 0, `stall` released.
- **Misaligned LW with the macro:** addr 0x102 → no `dmem_req`, `misaligned` = 1 for 1 cycle, `stall` = 0. Without the macro → access to 0x100 proceeds.
- **Reset mid-BUSY, then back-to-back accesses:** reset during BUSY → next cycle `dmem_req` = 0 and state IDLE. Two consecutive loads → second request issued the cycle after DONE.
